// File: rtl/tlpcpl_axis_tx_pkg.sv
// Shared TLP datapath definitions: framing FSM encodings, AXIS CC tuser layout
// and dword-enable helpers.
package tlpcpl_axis_tx_pkg;

    typedef enum logic {
        FRM_IDLE   = 1'b0,
        FRM_IN_PKT = 1'b1
    } frm_state_e;

    // tuser on the completer-completion stream carries only the discontinue bit
    localparam int CC_TUSER_W       = 1;
    localparam int CC_TUSER_DISCONT = 0;

    // True when be is non-zero and its set bits run contiguously up from bit 0
    function automatic logic be_contig(input logic [7:0] be);
        return (be != 8'h00) && ((be & (be + 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/tlpcpl_axis_tx_if.sv
// Completion-beat input stream plus AXIS completer-completion output stream.
// slave = the block consuming completion beats; master = the side producing them.
interface tlpcpl_axis_tx_if
    import tlpcpl_axis_tx_pkg::*;
#(
    parameter int PCIE_BUS_WIDTH = 256
) ();
    localparam int DW = PCIE_BUS_WIDTH / 32;

    logic                      cpl_request;
    logic [PCIE_BUS_WIDTH-1:0] cpl_data;
    logic [DW-1:0]             cpl_byteen;
    logic                      cpl_sof;
    logic                      cpl_eof;
    logic                      cpl_rdy;

    logic                      m_axis_cc_tvalid;
    logic                      m_axis_cc_tready;
    logic [PCIE_BUS_WIDTH-1:0] m_axis_cc_tdata;
    logic [DW-1:0]             m_axis_cc_tkeep;
    logic                      m_axis_cc_tlast;
    logic [CC_TUSER_W-1:0]     m_axis_cc_tuser;

    modport slave (
        input  cpl_request, cpl_data, cpl_byteen, cpl_sof, cpl_eof,
        output cpl_rdy,
        output m_axis_cc_tvalid, m_axis_cc_tdata, m_axis_cc_tkeep,
        output m_axis_cc_tlast, m_axis_cc_tuser,
        input  m_axis_cc_tready
    );

    modport master (
        output cpl_request, cpl_data, cpl_byteen, cpl_sof, cpl_eof,
        input  cpl_rdy,
        input  m_axis_cc_tvalid, m_axis_cc_tdata, m_axis_cc_tkeep,
        input  m_axis_cc_tlast, m_axis_cc_tuser,
        output m_axis_cc_tready
    );

endinterface

// File: rtl/tlp_skid_buffer.sv
// Purpose: 2-entry skid buffer that fully decouples push and pop timing.
// Latency: a push into an empty buffer appears on pop_vld the next cycle.
// Backpressure: push_rdy is registered and high whenever fewer than 2 entries are held.
module tlp_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         rdy_q;
    logic         push;
    logic         pop;

    assign push     = push_vld & rdy_q;
    assign pop      = pop_vld & pop_rdy;
    assign cnt_d    = cnt_q + 2'(push) - 2'(pop);
    assign push_rdy = rdy_q;
    assign pop_vld  = (cnt_q != 2'd0);
    assign pop_dat  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            rdy_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
            // Ready tracks the occupancy after this edge, so a pop from full reopens it next cycle
            rdy_q <= (cnt_d != 2'd2);
        end
    end

endmodule

// File: rtl/tlpcpl_axis_tx.sv
// Purpose: frames completion beats onto AXIS CC, checks sof/eof/byteen and counts TLPs.
// Latency: 1 cycle input-to-tvalid through a 2-entry skid buffer, 1 beat/cycle sustained.
// Backpressure: cpl_rdy is registered and drops only when both buffer entries are occupied.
module tlpcpl_axis_tx
    import tlpcpl_axis_tx_pkg::*;
#(
    parameter int PCIE_BUS_WIDTH = 256
) (
    input  logic             clk,
    input  logic             srst,
    tlpcpl_axis_tx_if.slave  bus,
    output logic             frame_err,
    output logic [31:0]      tlp_count
);

    localparam int DW = PCIE_BUS_WIDTH / 32;

    typedef struct packed {
        logic                      tuser;
        logic                      tlast;
        logic [DW-1:0]             keep;
        logic [PCIE_BUS_WIDTH-1:0] data;
    } cc_beat_t;

    frm_state_e state_q, state_d;
    logic       err_flag_q, err_flag_d;
    logic       frame_err_q;
    logic [31:0] tlp_count_q;

    logic       accept;
    logic       be_ok;
    logic       fwd;
    logic       seq_err;
    logic       be_err;
    logic       pkt_err;
    logic       beat_tuser;
    logic       push_vld;
    cc_beat_t   push_beat;
    cc_beat_t   pop_beat;

    assign accept = bus.cpl_request & bus.cpl_rdy;
    assign be_ok  = bus.cpl_eof ? be_contig(8'(bus.cpl_byteen))
                                : (bus.cpl_byteen == '1);

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= FRM_IDLE;
            err_flag_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_flag_q  <= err_flag_d;
            frame_err_q <= seq_err | be_err;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_flag_d = err_flag_q;
        fwd        = 1'b0;
        seq_err    = 1'b0;
        be_err     = 1'b0;
        pkt_err    = 1'b0;
        beat_tuser = 1'b0;
        if (accept) begin
            unique case (state_q)
                FRM_IDLE: begin
                    if (bus.cpl_sof) begin
                        fwd     = 1'b1;
                        state_d = bus.cpl_eof ? FRM_IDLE : FRM_IN_PKT;
                    end else begin
                        seq_err = 1'b1;
                    end
                end
                FRM_IN_PKT: begin
                    // A stray sof restarts the TLP; the truncated one never gets a tlast
                    fwd     = 1'b1;
                    seq_err = bus.cpl_sof;
                    state_d = bus.cpl_eof ? FRM_IDLE : FRM_IN_PKT;
                end
                default: state_d = FRM_IDLE;
            endcase
            be_err     = fwd & ~be_ok;
            pkt_err    = (state_q == FRM_IN_PKT) & (seq_err | be_err);
            beat_tuser = bus.cpl_eof & (err_flag_q | pkt_err);
            if (fwd & bus.cpl_eof) err_flag_d = 1'b0;
            else if (pkt_err)      err_flag_d = 1'b1;
        end
    end

    assign push_vld  = accept & fwd;
    assign push_beat = {beat_tuser, bus.cpl_eof, bus.cpl_byteen, bus.cpl_data};

    tlp_skid_buffer #(
        .W ($bits(cc_beat_t))
    ) u_skid (
        .clk      (clk),
        .srst     (srst),
        .push_vld (push_vld),
        .push_rdy (bus.cpl_rdy),
        .push_dat (push_beat),
        .pop_vld  (bus.m_axis_cc_tvalid),
        .pop_rdy  (bus.m_axis_cc_tready),
        .pop_dat  (pop_beat)
    );

    assign bus.m_axis_cc_tdata = pop_beat.data;
    assign bus.m_axis_cc_tkeep = pop_beat.keep;
    assign bus.m_axis_cc_tlast = pop_beat.tlast;

    always_comb begin
        bus.m_axis_cc_tuser                   = '0;
        bus.m_axis_cc_tuser[CC_TUSER_DISCONT] = pop_beat.tuser;
    end

    always_ff @(posedge clk) begin
        if (srst)
            tlp_count_q <= 32'd0;
        else if (bus.m_axis_cc_tvalid & bus.m_axis_cc_tready & bus.m_axis_cc_tlast)
            tlp_count_q <= tlp_count_q + 32'd1;
    end

    assign frame_err = frame_err_q;
    assign tlp_count = tlp_count_q;

endmodule
